keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4, is the number of consecutive stable tick_scan samples needed to accept a press or a release (legal range 2..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tick_scan  input  1  single-cycle scan strobe; may be asserted on consecutive cycles.
REQ-005 key_row  input  4  keypad row lines, active-low (pulled up; 0 = key closed on driven column), asynchronous to clk.
REQ-006 key_col  output  4  keypad column drive, active-low; exactly one bit is 0 outside reset.
REQ-007 key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}; holds its value until the next accepted press.
REQ-008 key_valid  output  1  one-clk pulse on press acceptance.
REQ-009 key_pressed  output  1  level, 1 from press acceptance to release acceptance.
REQ-010 key_release  output  1  one-clk pulse on release acceptance.

Function
REQ-011 key_row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value row_s.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD.
REQ-013 In SCAN, on each tick_scan with row_s == 4'hF, col_idx SHALL advance 0->1->2->3->0 (wrap) and key_col SHALL be ~(1<<col_idx), registered.
REQ-014 In SCAN, on tick_scan with any row_s bit 0, the FSM SHALL latch col_idx and the lowest-index low row as row_idx, clear cnt, enter DEBOUNCE, and not advance the column.
REQ-015 In DEBOUNCE, col_idx and key_col SHALL stay frozen.
REQ-016 In DEBOUNCE, on each tick_scan with row_s[row_idx] == 0, cnt SHALL increment.
REQ-017 The tick on which the count of consecutive low samples reaches DEBOUNCE_TICKS (including the entry sample) SHALL cause entry to HELD.
REQ-018 In DEBOUNCE, on tick_scan with row_s[row_idx] == 1, the FSM SHALL return to SCAN and advance col_idx by one.
REQ-019 On DEBOUNCE->HELD, key_code SHALL load {row_idx, col_idx} and key_pressed SHALL go 1.
REQ-020 On DEBOUNCE->HELD, key_valid SHALL be 1 for exactly the clk cycle after the accepting tick.
REQ-021 In HELD, the column SHALL stay frozen.
REQ-022 In HELD, each tick_scan with row_s[row_idx] == 1 SHALL increment cnt, and each tick with it 0 SHALL clear cnt.
REQ-023 In HELD, after DEBOUNCE_TICKS consecutive high samples, the FSM SHALL go to SCAN, clear key_pressed, and pulse key_release for one cycle.
REQ-024 On HELD->SCAN, the FSM SHALL advance col_idx.
REQ-025 Other rows going low while in HELD SHALL be ignored (no rollover; single-key).
REQ-026 Cycles without tick_scan SHALL change no state other than the synchronizer.
REQ-027 cnt SHALL be 4 bits and saturate, never wrapping.
REQ-028 key_valid and key_release SHALL never be asserted in the same cycle.

Reset
REQ-029 rst SHALL asynchronously force: state SCAN, col_idx 0, key_col 4'b1110, cnt 0, synchronizer flops 4'hF, key_code 0, key_valid 0, key_pressed 0, key_release 0.
REQ-030 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort without any key_valid or key_release pulse.

Structure
REQ-031 A shared package SHALL hold the state enum (SCAN/DEBOUNCE/HELD), KEY_ROWS=4, and KEY_COLS=4.
REQ-032 The synchronizer SHALL be a sub-module sync_2ff (width parameter, reset value parameter), reusable by other switch inputs.

Verification
REQ-033 No key, 8 ticks -> key_col sequence 1110,1101,1011,0111,1110,...; no key_valid.
REQ-034 Key at row 2/col 1 closed and held; 4 qualifying ticks -> key_code 4'b1001, one key_valid pulse, key_pressed 1, and key_col stays 1101 while held.
REQ-035 Row 2/col 1 bounces (low 2 ticks, high 1) -> return to SCAN, key_col advances to 1011, no key_valid.
REQ-036 Release after REQ-034 with a 1-tick low glitch mid-release -> cnt restarts; key_release arrives only after 4 consecutive highs; key_pressed 0.
REQ-037 Rows 1 and 3 low on col 0 -> key_code 4'b0100.
REQ-038 rst pulse during HELD -> all outputs at reset values immediately, with no key_release pulse.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner.
package keypad_scanner_pkg;

    localparam int unsigned KEY_ROWS = 4;
    localparam int unsigned KEY_COLS = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index of the lowest-numbered row line that is pulled low.
    function automatic logic [IDX_W-1:0] lowest_low(input logic [KEY_ROWS-1:0] row);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = KEY_ROWS - 1; i >= 0; i--) begin
            if (!row[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous switch inputs.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing, single-key.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_scan,
    input  logic [KEY_ROWS-1:0] key_row,
    output logic [KEY_COLS-1:0] key_col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_pressed,
    output logic                key_release
);

    // The entry sample of a press counts toward the total but leaves cnt at 0.
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(DEBOUNCE_TICKS - 2);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [KEY_ROWS-1:0] row_s;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic [IDX_W-1:0]    row_idx_q, row_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KEY_COLS-1:0] key_col_q, key_col_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_pressed_q, key_pressed_d;
    logic                key_release_q, key_release_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                row_hit;

    sync_2ff #(
        .WIDTH   (KEY_ROWS),
        .RST_VAL ({KEY_ROWS{1'b1}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_row),
        .q   (row_s)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign row_hit = ~row_s[row_idx_q];

    // Next-state and output decode; only tick_scan cycles change state.
    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        cnt_d         = cnt_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;

        if (tick_scan) begin
            case (state_q)
                SCAN: begin
                    if (&row_s) begin
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end else begin
                        row_idx_d = lowest_low(row_s);
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= PRESS_LAST) begin
                            state_d       = HELD;
                            cnt_d         = '0;
                            key_code_d    = {row_idx_q, col_idx_q};
                            key_pressed_d = 1'b1;
                            key_valid_d   = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= REL_LAST) begin
                            state_d       = SCAN;
                            cnt_d         = '0;
                            col_idx_d     = col_idx_q + IDX_W'(1);
                            key_pressed_d = 1'b0;
                            key_release_d = 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        key_col_d = ~(KEY_COLS'(1) << col_idx_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SCAN;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            cnt_q         <= '0;
            key_col_q     <= 4'b1110;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            cnt_q         <= cnt_d;
            key_col_q     <= key_col_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_col     = key_col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: a keypad matrix model drives key_row from key_col.
module tb_keypad_scanner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_scan;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       key_release;

    // pressed[r][c] = 1 when the switch at row r / column c is closed
    logic [3:0][3:0] pressed;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_rel;
        logic [3:0] code;
    } ev_t;
    ev_t evq[$];
    ev_t mon_ev;

    // Reference model state: 0 idle scanning, 1 qualifying a press, 2 key held
    int         m_col;
    int         m_mode;
    int         m_row;
    int         m_run;
    logic [3:0] m_code;

    keypad_scanner #(.DEBOUNCE_TICKS(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_scan   (tick_scan),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Closed switch on a driven (low) column pulls its row low.
    always_comb begin
        for (int r = 0; r < 4; r++) key_row[r] = ~|(pressed[r] & ~key_col);
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_col  = 0;
        m_mode = 0;
        m_row  = 0;
        m_run  = 0;
        m_code = 4'h0;
    endfunction

    // One accepted scan tick, evaluated from the matrix as seen on the model's column.
    function automatic void model_step();
        logic [3:0] rows;
        ev_t        e;
        for (int r = 0; r < 4; r++) rows[r] = ~pressed[r][m_col];
        case (m_mode)
            0: begin
                if (rows == 4'hF) begin
                    m_col = (m_col + 1) % 4;
                end else begin
                    m_row = 3;
                    for (int r = 3; r >= 0; r--) if (!rows[r]) m_row = r;
                    m_run  = 1;
                    m_mode = 1;
                end
            end
            1: begin
                if (!rows[m_row]) begin
                    m_run++;
                    if (m_run >= D) begin
                        m_mode   = 2;
                        m_run    = 0;
                        m_code   = 4'(m_row * 4 + m_col);
                        e.is_rel = 1'b0;
                        e.code   = m_code;
                        evq.push_back(e);
                    end
                end else begin
                    m_mode = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end
            default: begin
                if (rows[m_row]) begin
                    m_run++;
                    if (m_run >= D) begin
                        e.is_rel = 1'b1;
                        e.code   = m_code;
                        evq.push_back(e);
                        m_mode = 0;
                        m_run  = 0;
                        m_col  = (m_col + 1) % 4;
                    end
                end else begin
                    m_run = 0;
                end
            end
        endcase
    endfunction

    task automatic check_levels();
        check("key_col", key_col, 4'(15 - (1 << m_col)));
        check("key_pressed", {3'b000, key_pressed}, {3'b000, m_mode == 2});
        check("key_code", key_code, m_code);
    endtask

    // Let key lines settle through the synchronizer, then issue one tick.
    task automatic do_tick(input int settle);
        repeat (settle) @(posedge clk);
        #1 tick_scan = 1'b1;
        model_step();
        @(posedge clk);
        #1 tick_scan = 1'b0;
        check_levels();
    endtask

    // Back-to-back ticks; only used with no switch closed so rows stay high.
    task automatic burst(input int n);
        @(posedge clk);
        #1 tick_scan = 1'b1;
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
        end
        tick_scan = 1'b0;
        check_levels();
    endtask

    task automatic tick_until_held(input string nm);
        int guard;
        guard = 0;
        while (m_mode != 2 && guard < 16) begin
            do_tick(6);
            guard++;
        end
        check(nm, {3'b000, key_pressed}, 4'b0001);
    endtask

    // Monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid && key_release) begin
                total++;
                bad++;
                $display("FAIL pulse_overlap: key_valid=1 key_release=1 at %0t, required not both", $time);
            end
            if (key_valid || key_release) begin
                if (evq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: key_valid=%0b key_release=%0b at %0t, required none",
                             key_valid, key_release, $time);
                end else begin
                    mon_ev = evq.pop_front();
                    check("event_kind", {3'b000, key_release}, {3'b000, mon_ev.is_rel});
                    if (!mon_ev.is_rel) check("event_code", key_code, mon_ev.code);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        tick_scan = 1'b0;
        pressed   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_col", key_col, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_outputs", {1'b0, key_valid, key_pressed, key_release}, 4'h0);
        rst = 1'b0;

        // Idle scan, including consecutive-cycle ticks
        burst(4);
        for (int i = 0; i < 4; i++) do_tick(6);

        // Row 2 / col 1 closed and held
        pressed[2][1] = 1'b1;
        tick_until_held("held_21");
        do_tick(6);
        do_tick(6);
        check("code_21", key_code, 4'b1001);
        check("col_held_21", key_col, 4'b1101);

        // Release with a one-tick glitch low in the middle
        pressed = '0;
        do_tick(6);
        do_tick(6);
        pressed[2][1] = 1'b1;
        do_tick(6);
        pressed = '0;
        for (int i = 0; i < D - 1; i++) do_tick(6);
        check("still_pressed", {3'b000, key_pressed}, 4'b0001);
        do_tick(6);
        check("released", {3'b000, key_pressed}, 4'b0000);

        // Bounce: low for two ticks then high -> back to scanning
        pressed[2][1] = 1'b1;
        for (int g = 0; g < 8 && m_mode == 0; g++) do_tick(6);
        do_tick(6);
        pressed = '0;
        do_tick(6);
        check("bounce_col", key_col, 4'b1011);

        // Rows 1 and 3 on column 0: lowest row wins
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        tick_until_held("held_multi");
        check("code_multi", key_code, 4'b0100);
        pressed[0][2] = 1'b1;
        do_tick(6);
        check("no_rollover", key_code, 4'b0100);
        pressed = '0;
        for (int i = 0; i < D; i++) do_tick(6);

        // Reset while held aborts silently
        pressed[0][3] = 1'b1;
        tick_until_held("held_03");
        do_tick(6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_key_col", key_col, 4'b1110);
        check("abort_key_code", key_code, 4'h0);
        check("abort_outputs", {1'b0, key_valid, key_pressed, key_release}, 4'h0);
        pressed = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        do_tick(6);

        // Random key activity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) begin
                int k;
                k = int'($urandom_range(9));
                if (k < 4) begin
                    pressed = '0;
                end else if (k < 9) begin
                    pressed = '0;
                    pressed[$urandom_range(3)][$urandom_range(3)] = 1'b1;
                end else begin
                    pressed = 16'($urandom);
                end
            end
            if (pressed == '0 && $urandom_range(7) == 0) begin
                repeat (4) @(posedge clk);
                burst(int'($urandom_range(2, 4)));
            end else begin
                do_tick(6 + int'($urandom_range(3)));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("pending_events", 4'(evq.size()), 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
